// File: rtl/pipeline_tap_reader.sv
// Circular-buffer delay line: returns the sample written `delay` strobes earlier, selectable at run time.
// Latency 1 clk from in_valid to out/out_valid/out_strobe; no backpressure, every strobe is accepted unless flushed.
module pipeline_tap_reader #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    MAX_DELAY  = 64,
  parameter logic [DATA_WIDTH-1:0] POR_VALUE  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   delay,
  output logic [DATA_WIDTH-1:0]            out,
  output logic                             out_valid,
  output logic                             out_strobe,
  output logic                             primed,
  output logic                             delay_err
);

  localparam int DW = $clog2(MAX_DELAY + 1);
  localparam int AW = $clog2(MAX_DELAY);

  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  logic [DATA_WIDTH-1:0] mem [MAX_DELAY];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         wp_next;
  logic [DW-1:0]         fill;
  logic [1:0]            state;

  logic                  accept;
  logic                  range_err;
  logic [DW-1:0]         d;
  logic [DW:0]           raddr_sum;
  logic [AW-1:0]         raddr;

  assign accept = in_valid & ~flush;
  assign primed = (state == FULL);

  always_comb begin
    range_err = (delay > DW'(MAX_DELAY));
    d         = range_err ? DW'(MAX_DELAY) : delay;
  end

  // (wp - d) mod MAX_DELAY without a divider; d==MAX_DELAY lands on wp itself
  always_comb begin
    raddr_sum = (DW+1)'(wp) + (DW+1)'(MAX_DELAY) - (DW+1)'(d);
    if (raddr_sum >= (DW+1)'(MAX_DELAY)) begin
      raddr_sum = raddr_sum - (DW+1)'(MAX_DELAY);
    end
    raddr = AW'(raddr_sum);
  end

  always_comb begin
    wp_next = (wp == AW'(MAX_DELAY - 1)) ? '0 : wp + AW'(1);
  end

  // Memory is never cleared; fill gating keeps stale entries off a valid output
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem[wp] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp         <= '0;
      fill       <= '0;
      state      <= EMPTY;
      out        <= POR_VALUE;
      out_valid  <= 1'b0;
      out_strobe <= 1'b0;
      delay_err  <= 1'b0;
    end else if (flush) begin
      wp         <= '0;
      fill       <= '0;
      state      <= EMPTY;
      out        <= POR_VALUE;
      out_valid  <= 1'b0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= in_valid;
      out_valid  <= 1'b0;
      if (in_valid) begin
        if (range_err) begin
          delay_err <= 1'b1;
        end

        // The read uses wp/fill from before this strobe's write, so the RAM is read-before-write
        if (d == '0) begin
          out       <= in;
          out_valid <= 1'b1;
        end else if (d <= fill) begin
          out       <= mem[raddr];
          out_valid <= 1'b1;
        end else begin
          out       <= POR_VALUE;
          out_valid <= 1'b0;
        end

        wp <= wp_next;
        if (fill != DW'(MAX_DELAY)) begin
          fill <= fill + DW'(1);
        end

        case (state)
          EMPTY:   state <= (MAX_DELAY == 1) ? FULL : FILLING;
          FILLING: if (fill == DW'(MAX_DELAY - 1)) state <= FULL;
          FULL:    state <= FULL;
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule
